// File: rtl/hand_dealer_if.sv
// Control and hand-state bundle of the blackjack hand dealer.
// The master drives the requests; the slave (the dealer) drives the hand state.
interface hand_dealer_if #(
    parameter int MAX_CARDS = 9
);
    logic       new_round;
    logic       deal_req;
    logic       inj_valid;
    logic [5:0] inj_code;
    logic [5:0] card_code [0:MAX_CARDS-1];
    logic [3:0] card_cnt;
    logic [6:0] hand_value;
    logic       bust;
    logic       busy;
    logic       deal_done;

    modport master (
        output new_round, deal_req, inj_valid, inj_code,
        input  card_code, card_cnt, hand_value, bust, busy, deal_done
    );

    modport slave (
        input  new_round, deal_req, inj_valid, inj_code,
        output card_code, card_cnt, hand_value, bust, busy, deal_done
    );
endinterface

// File: rtl/hand_dealer.sv
// Blackjack hand dealer: draws unique cards from an LFSR (or an injected code)
// into up to MAX_CARDS slots and keeps a registered best score and bust flag.
//
// state | meaning
// IDLE  | waiting for deal_req
// DRAW  | latch candidate card (injected code or LFSR draw)
// CHECK | reject out-of-range or duplicate candidate
// STORE | write candidate into the next free slot
// SCORE | register hand value and bust, pulse deal_done
module hand_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_CARDS = 9
) (
    input  logic         clk,
    input  logic         rst,
    hand_dealer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAW  = 3'd1,
        CHECK = 3'd2,
        STORE = 3'd3,
        SCORE = 3'd4
    } state_t;

    localparam logic [3:0] CNT_FULL = 4'(MAX_CARDS);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [5:0]  slots [0:MAX_CARDS-1];
    logic [5:0]  cand;
    logic        cand_inj;
    logic        cand_dup;
    logic        cand_bad;
    logic [3:0]  card_cnt;
    logic [6:0]  hand_value;
    logic [6:0]  sum;
    logic [6:0]  score_nxt;
    logic        has_ace;
    logic        bust;
    logic        deal_done;
    logic        busy;
    logic        draw_en;
    logic        store_en;
    logic        score_en;

    function automatic logic [6:0] card_points(input logic [5:0] code);
        logic [5:0] r;
        r = (code - 6'd1) % 6'd13;
        if (r == 6'd0)
            card_points = 7'd1;
        else if (r < 6'd10)
            card_points = 7'(r) + 7'd1;
        else
            card_points = 7'd10;
    endfunction

    // Free-running maximal-length sequence; a non-zero seed keeps it non-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Empty slots hold 0, which a valid candidate can never equal.
    always_comb begin
        cand_dup = 1'b0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (slots[i] == cand)
                cand_dup = 1'b1;
        end
        cand_bad = (cand == 6'd0) || (cand > 6'd52) || cand_dup;
    end

    always_comb begin
        state_nxt = state;
        if (bus.new_round) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.deal_req && (card_cnt < CNT_FULL)) state_nxt = DRAW;
                DRAW:    state_nxt = CHECK;
                CHECK: begin
                    if (!cand_bad)
                        state_nxt = STORE;
                    else if (cand_inj)
                        state_nxt = IDLE;
                    else
                        state_nxt = DRAW;
                end
                STORE:   state_nxt = SCORE;
                SCORE:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        draw_en  = (state == DRAW);
        store_en = (state == STORE);
        score_en = (state == SCORE);
    end

    always_comb begin
        sum     = 7'd0;
        has_ace = 1'b0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (slots[i] != 6'd0) begin
                sum = sum + card_points(slots[i]);
                if (card_points(slots[i]) == 7'd1)
                    has_ace = 1'b1;
            end
        end
        score_nxt = (has_ace && ((sum + 7'd10) <= 7'd21)) ? (sum + 7'd10) : sum;
    end

    // new_round outranks every datapath update, including a pending deal_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_CARDS; i++)
                slots[i] <= 6'd0;
            cand       <= 6'd0;
            cand_inj   <= 1'b0;
            card_cnt   <= 4'd0;
            hand_value <= 7'd0;
            bust       <= 1'b0;
            deal_done  <= 1'b0;
        end else if (bus.new_round) begin
            for (int i = 0; i < MAX_CARDS; i++)
                slots[i] <= 6'd0;
            card_cnt   <= 4'd0;
            hand_value <= 7'd0;
            bust       <= 1'b0;
            deal_done  <= 1'b0;
        end else begin
            deal_done <= score_en;
            if (draw_en) begin
                cand     <= bus.inj_valid ? bus.inj_code : (lfsr[5:0] + 6'd1);
                cand_inj <= bus.inj_valid;
            end
            if (store_en) begin
                for (int i = 0; i < MAX_CARDS; i++) begin
                    if (4'(i) == card_cnt)
                        slots[i] <= cand;
                end
                card_cnt <= card_cnt + 4'd1;
            end
            if (score_en) begin
                hand_value <= score_nxt;
                bust       <= (score_nxt > 7'd21);
            end
        end
    end

    assign bus.card_code  = slots;
    assign bus.card_cnt   = card_cnt;
    assign bus.hand_value = hand_value;
    assign bus.bust       = bust;
    assign bus.busy       = busy;
    assign bus.deal_done  = deal_done;
endmodule

// File: doc/hand_dealer.md
HAND_DEALER -- requirements
Module: hand_dealer

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, meaning the non-zero LFSR value loaded at reset.
REQ-002 Parameter MAX_CARDS, default 9, meaning the number of card slots per hand (one per card drawing slot).
REQ-003 clk  input  1  meaning the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 new_round  input  1  meaning a one-cycle pulse that clears the hand.
REQ-006 deal_req  input  1  meaning a one-cycle pulse that draws one card into the next free slot.
REQ-007 inj_valid  input  1  meaning the test/debug path is active: inj_code replaces the LFSR draw.
REQ-008 inj_code  input  6  meaning the injected card code, 1..52.
REQ-009 card_code[0:MAX_CARDS-1]  output  6 each  meaning the per-slot card code, where 0 means empty and 1..52 equals suit*13 + rank.
REQ-010 card_cnt  output  4  meaning the number of filled slots.
REQ-011 hand_value  output  7  meaning the best blackjack score of the filled slots.
REQ-012 bust  output  1  meaning hand_value > 21.
REQ-013 busy  output  1  meaning the block is not in IDLE.
REQ-014 deal_done  output  1  meaning a one-cycle pulse when a deal completes.

Function
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock and SHALL never hold the value 0.
REQ-016 The FSM SHALL have the states IDLE, DRAW, CHECK, STORE and SCORE.
REQ-017 In IDLE, a deal_req with card_cnt < MAX_CARDS SHALL move the FSM to DRAW.
REQ-018 A deal_req in IDLE with card_cnt = MAX_CARDS SHALL be ignored: no state change and no deal_done.
REQ-019 A deal_req while busy = 1 SHALL be ignored, with no queueing.
REQ-020 DRAW SHALL latch the candidate = inj_code when inj_valid = 1, else lfsr[5:0] + 1, and then go to CHECK.
REQ-021 CHECK SHALL reject the candidate (go back to DRAW) if it is 0, greater than 52, or equal to any filled slot; otherwise it SHALL go to STORE.
REQ-022 An injected candidate that CHECK rejects SHALL abort the deal: the FSM goes to IDLE with no store and no deal_done.
REQ-023 STORE SHALL write the candidate to card_code[card_cnt], increment card_cnt, and go to SCORE.
REQ-024 Rank value rules: r = (code-1) mod 13; r = 0 is an ace worth 1; r of 1..9 is worth r+1; r of 10..12 is worth 10.
REQ-025 SCORE SHALL register hand_value = sum + 10 if an ace is present and sum + 10 <= 21, else sum.
REQ-026 SCORE SHALL register bust = (hand_value > 21), pulse deal_done for exactly one cycle, and return to IDLE.
REQ-027 The minimum latency from deal_req to deal_done SHALL be 4 cycles, with each rejection adding 2 cycles.
REQ-028 hand_value and bust SHALL update only in SCORE or on a clear.
REQ-029 new_round in any state SHALL, on the next edge, zero all card_code slots, card_cnt, hand_value and bust, force the FSM to IDLE, and suppress any pending deal_done.
REQ-030 When new_round and deal_req occur in the same cycle, new_round SHALL win and deal_req SHALL be dropped.
REQ-031 The 7-bit hand_value SHALL not overflow, since the maximum sum of 9 slots is 90.

Reset
REQ-032 rst = 0 SHALL immediately and asynchronously clear the FSM to IDLE, all card_code slots to 0, and card_cnt, hand_value, bust, busy and deal_done to 0, and SHALL load the LFSR with LFSR_SEED.
REQ-033 Reset asserted mid-deal SHALL abandon the deal, with no partial slot write visible after reset.
REQ-034 Release of reset SHALL be synchronised by the system; the block SHALL be operational on the first edge after release.

Verification
REQ-035 Reset: after rst low, all outputs are 0; after release, busy = 0 and the LFSR is non-zero.
REQ-036 Ace and king: inject 1, then 13 -> card_code[0] = 1, card_code[1] = 13, card_cnt = 2, hand_value = 21, bust = 0, with deal_done 4 cycles after each deal_req.
REQ-037 Bust: inject 10, 11, 12 (values 10, J, Q) -> hand_value = 30, bust = 1; then new_round -> all slots 0 and hand_value = 0.
REQ-038 Duplicate and invalid injects: inject 5, then 5 -> second deal aborts, card_cnt = 1, no deal_done; inject 60 -> aborts likewise.
REQ-039 Full hand: 9 random deals -> 9 distinct codes in 1..52; a 10th deal_req -> no busy, no deal_done, outputs unchanged.
REQ-040 Collisions: new_round with deal_req in the same cycle -> cleared hand, busy = 0; deal_req held during busy -> exactly one card added.
